count_display_scanner: RTL and testbench

- Consumes the 24-bit free-running ripple count and shows it as 6 hex digits on a time-multiplexed, common-anode 7-segment display.
- Filters ripple glitches on the asynchronous count before capture.
- Latches one full frame at a time so scanned digits never tear.
- Drives anodes, segments and decimal point directly.

---
 rtl/count_disp_pkg.sv | 15 +
 rtl/hex7seg_decoder.sv | 11 +
 rtl/count_display_scanner.sv | 85 ++++++++
 tb/tb_count_display_scanner.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/count_disp_pkg.sv
// rtl/count_disp_pkg.sv - shared constants for the 6-digit hex count display
package count_disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex value 0..F
  localparam logic [6:0] HEX7 [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex7seg_decoder.sv
// rtl/hex7seg_decoder.sv - nibble to active-low 7-segment pattern
module hex7seg_decoder
  import count_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7[nibble_i];

endmodule

// File: rtl/count_display_scanner.sv
// rtl/count_display_scanner.sv - deglitched capture and multiplexed 6-digit hex display
module count_display_scanner
  import count_disp_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] count_in,
  input  logic        hold,
  output logic [6:0]  seg_out,
  output logic [5:0]  an_out,
  output logic        dp_out
);

  localparam int PRE_W = 16;
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic [23:0]      s1_q, s2_q, snap_q, frame_q;
  logic [23:0]      snap_d, frame_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       digit_q, digit_d;
  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic        tick;
  logic        blank;
  logic [4:0]  shamt;
  logic [23:0] upper;
  logic [6:0]  dec_seg;

  hex7seg_decoder u_dec (
    .nibble_i (upper[3:0]),
    .seg_o    (dec_seg)
  );

  always_comb begin
    tick    = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d   = tick ? '0 : pre_q + 1'b1;
    digit_d = digit_q;
    if (tick) begin
      digit_d = (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
    end

    // Only a value seen identically on two consecutive samples is trusted
    snap_d  = (s1_q == s2_q) ? s2_q : snap_q;
    frame_d = (tick && digit_q == LAST_DIGIT && !hold) ? snap_q : frame_q;

    // Shifting the frame down puts the current nibble at [3:0] and leaves
    // exactly the bits that must all be zero for leading-zero blanking
    shamt = {digit_q, 2'b00};
    upper = frame_q >> shamt;
    blank = BLANK_LZ && (digit_q != 3'd0) && (upper == '0);
    an_d  = blank ? 6'b111111 : ~(6'b000001 << digit_q);
    seg_d = blank ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      snap_q  <= '0;
      frame_q <= '0;
      pre_q   <= '0;
      digit_q <= '0;
      an_q    <= 6'b111111;
      seg_q   <= SEG_BLANK;
    end else begin
      s1_q    <= count_in;
      s2_q    <= s1_q;
      snap_q  <= snap_d;
      frame_q <= frame_d;
      pre_q   <= pre_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an_out  = an_q;
  assign seg_out = seg_q;
  assign dp_out  = 1'b1;

endmodule

// File: tb/tb_count_display_scanner.sv
// tb/tb_count_display_scanner.sv - scoreboard bench for count_display_scanner
module tb_count_display_scanner;

  localparam int BASE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [23:0] count_in;
  logic [6:0]  seg_out;
  logic [5:0]  an_out;
  logic        dp_out;

  count_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .hold     (hold),
    .seg_out  (seg_out),
    .an_out   (an_out),
    .dp_out   (dp_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         cyc;
    logic [5:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t vecs[$];
  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(string n, int k, logic [5:0] an, logic [6:0] seg);
    exp_t e;
    e.name = n;
    e.cyc  = BASE + k;
    e.an   = an;
    e.seg  = seg;
    vecs.push_back(e);
  endfunction

  // k counts posedges after reset release; k <= 0 are the reset posedges
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      n_vec++;
      if (mon_e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", mon_e.name, mon_e.cyc, cyc);
      end else if (an_out !== mon_e.an || seg_out !== mon_e.seg || dp_out !== 1'b1) begin
        n_bad++;
        $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=1",
                 mon_e.name, an_out, seg_out, dp_out, mon_e.an, mon_e.seg);
      end
    end
  end

  task automatic to_rel(input int k);
    while (cyc < BASE + k) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b0;
    hold     = 1'b0;
    count_in = 24'h00A3F0;

    add("rst1",          -2, 6'b111111, 7'b1111111);
    add("rst2",          -1, 6'b111111, 7'b1111111);
    add("rst3",           0, 6'b111111, 7'b1111111);
    add("first_out",      1, 6'b111110, 7'b1000000);
    add("slot0_end",      4, 6'b111110, 7'b1000000);
    add("zero_d1_blank",  5, 6'b111111, 7'b1111111);
    add("zero_d5_blank", 24, 6'b111111, 7'b1111111);
    add("a3f0_d0",       25, 6'b111110, 7'b1000000);
    add("a3f0_d1",       29, 6'b111101, 7'b0001110);
    add("a3f0_d2",       33, 6'b111011, 7'b0110000);
    add("a3f0_d3",       37, 6'b110111, 7'b0001000);
    add("a3f0_d4_blank", 41, 6'b111111, 7'b1111111);
    add("a3f0_d5_blank", 45, 6'b111111, 7'b1111111);
    add("a3f0_wrap_d0",  49, 6'b111110, 7'b1000000);
    add("glitch_d0",     73, 6'b111110, 7'b1000000);
    add("glitch_d1",     77, 6'b111101, 7'b0001110);
    add("glitch_d5",     96, 6'b111111, 7'b1111111);
    add("stable7_d0",    97, 6'b111110, 7'b1111000);
    add("stable7_d1",   101, 6'b111111, 7'b1111111);
    add("show5",        121, 6'b111110, 7'b0010010);
    add("hold_f1",      145, 6'b111110, 7'b0010010);
    add("hold_f2",      169, 6'b111110, 7'b0010010);
    add("hold_f3",      193, 6'b111110, 7'b0010010);
    add("unhold9",      217, 6'b111110, 7'b0010000);
    add("ffs_d0",       241, 6'b111110, 7'b0001110);
    add("ffs_d1",       245, 6'b111101, 7'b0001110);
    add("ffs_d2",       249, 6'b111011, 7'b0001110);
    add("ffs_d3",       253, 6'b110111, 7'b0001110);
    add("ffs_d4",       257, 6'b101111, 7'b0001110);
    add("ffs_d5",       261, 6'b011111, 7'b0001110);
    add("ffs_d5_end",   264, 6'b011111, 7'b0001110);
    add("ffs_wrap_d0",  265, 6'b111110, 7'b0001110);
    add("midrst",       280, 6'b111111, 7'b1111111);
    add("midrst_rel",   281, 6'b111110, 7'b1000000);
    add("midrst_d1",    285, 6'b111111, 7'b1111111);
    add("midrst_d5",    304, 6'b111111, 7'b1111111);
    add("midrst_ld_d0", 305, 6'b111110, 7'b0001110);
    add("midrst_ld_d1", 309, 6'b111101, 7'b0001110);

    for (int i = 0; i < vecs.size(); i++) sbq.push_back(vecs[i]);

    to_rel(0);
    reset = 1'b1;

    // A count that changes every cycle must never pass the filter
    to_rel(49);
    for (int i = 0; i < 40; i++) begin
      count_in = 24'h000100 + 24'(i);
      @(negedge clk);
    end
    count_in = 24'h000007;

    to_rel(97);
    count_in = 24'h000005;

    to_rel(121);
    hold     = 1'b1;
    count_in = 24'h000009;

    to_rel(193);
    hold = 1'b0;

    to_rel(217);
    count_in = 24'hFFFFFF;

    // Reset lands on the digit-3 slot's tick edge
    to_rel(279);
    reset = 1'b0;
    to_rel(280);
    reset = 1'b1;

    to_rel(320);
    while (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: never checked (due cycle %0d)", mon_e.name, mon_e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
